// File: rtl/rf_ctrl_pkg.sv
// Shared constants and types for the register-file control slice.
package rf_ctrl_pkg;
    localparam int RF_DATA_W   = 32;
    localparam int RF_ADDR_W   = 5;
    localparam int RF_NUM_REGS = 32;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } wb_src_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; the last-grant register moves only on a grant.
module rr_arb2
    import rf_ctrl_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    req_alu,
    input  logic    req_mem,
    output logic    gnt_alu,
    output logic    gnt_mem,
    output wb_src_t rr_last
);

    always_comb begin
        gnt_alu = 1'b0;
        gnt_mem = 1'b0;
        // On contention the source that did not win last time goes first.
        gnt_alu = req_alu && (!req_mem || (rr_last == SRC_MEM));
        gnt_mem = req_mem && !gnt_alu;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_last <= SRC_MEM;
        end else if (gnt_alu) begin
            rr_last <= SRC_ALU;
        end else if (gnt_mem) begin
            rr_last <= SRC_MEM;
        end
    end

endmodule

// File: rtl/rf_wb_scheduler.sv
// Write-back scheduler: shares the register-file write port between ALU and loads,
// and keeps a scoreboard of destinations with uncommitted writes.
module rf_wb_scheduler
    import rf_ctrl_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 iss_valid,
    input  logic [ADDR_W-1:0]    iss_rd,
    output logic                 iss_ready,
    input  logic [ADDR_W-1:0]    rs_addr,
    input  logic [ADDR_W-1:0]    rt_addr,
    output logic                 hazard,
    input  logic                 alu_valid,
    input  logic [ADDR_W-1:0]    alu_rd,
    input  logic [DATA_W-1:0]    alu_data,
    output logic                 alu_ready,
    input  logic                 mem_valid,
    input  logic [ADDR_W-1:0]    mem_rd,
    input  logic [DATA_W-1:0]    mem_data,
    output logic                 mem_ready,
    output logic                 RegWrite,
    output logic [ADDR_W-1:0]    RD_Address,
    output logic [DATA_W-1:0]    RDdata,
    output logic [2**ADDR_W-1:0] busy_vec
);

    localparam int NUM_REGS = 2**ADDR_W;

    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_next;
    logic                gnt_alu;
    logic                gnt_mem;
    wb_src_t             rr_last;
    wb_src_t             gnt_src;
    logic [ADDR_W-1:0]   wb_rd;
    logic [DATA_W-1:0]   wb_data;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req_alu (alu_valid),
        .req_mem (mem_valid),
        .gnt_alu (gnt_alu),
        .gnt_mem (gnt_mem),
        .rr_last (rr_last)
    );

    assign alu_ready = gnt_alu;
    assign mem_ready = gnt_mem;
    assign busy_vec  = busy;

    always_comb begin
        iss_ready = !(busy[iss_rd] && (iss_rd != '0));
        hazard    = (busy[rs_addr] && (rs_addr != '0)) ||
                    (busy[rt_addr] && (rt_addr != '0));
        gnt_src   = gnt_mem ? SRC_MEM : SRC_ALU;
        wb_rd     = (gnt_src == SRC_MEM) ? mem_rd   : alu_rd;
        wb_data   = (gnt_src == SRC_MEM) ? mem_data : alu_data;
    end

    // Clear is applied after set so it wins if both hit the same register.
    always_comb begin
        busy_next = busy;
        if (iss_valid && iss_ready && (iss_rd != '0)) begin
            busy_next[iss_rd] = 1'b1;
        end
        if (RegWrite) begin
            busy_next[RD_Address] = 1'b0;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            RegWrite   <= 1'b0;
            RD_Address <= '0;
            RDdata     <= '0;
        end else if (gnt_alu || gnt_mem) begin
            RegWrite   <= (wb_rd != '0);
            RD_Address <= wb_rd;
            RDdata     <= wb_data;
        end else begin
            RegWrite   <= 1'b0;
        end
    end

    a_rr_order: assert property (@(posedge clk) disable iff (rst)
        (alu_valid && mem_valid) |-> (alu_ready == (rr_last == SRC_MEM)));

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Self-checking bench for rf_wb_scheduler: directed scenarios plus a randomized run
// against a cycle-level reference model of the scheduling rules.
module tb_rf_wb_scheduler;
    import rf_ctrl_pkg::*;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 32;

    logic          clk;
    logic          rst;
    logic          iss_valid;
    logic [AW-1:0] iss_rd;
    logic          iss_ready;
    logic [AW-1:0] rs_addr;
    logic [AW-1:0] rt_addr;
    logic          hazard;
    logic          alu_valid;
    logic [AW-1:0] alu_rd;
    logic [DW-1:0] alu_data;
    logic          alu_ready;
    logic          mem_valid;
    logic [AW-1:0] mem_rd;
    logic [DW-1:0] mem_data;
    logic          mem_ready;
    logic          RegWrite;
    logic [AW-1:0] RD_Address;
    logic [DW-1:0] RDdata;
    logic [NR-1:0] busy_vec;

    int tests;
    int fails;

    rf_wb_scheduler #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .iss_valid  (iss_valid),
        .iss_rd     (iss_rd),
        .iss_ready  (iss_ready),
        .rs_addr    (rs_addr),
        .rt_addr    (rt_addr),
        .hazard     (hazard),
        .alu_valid  (alu_valid),
        .alu_rd     (alu_rd),
        .alu_data   (alu_data),
        .alu_ready  (alu_ready),
        .mem_valid  (mem_valid),
        .mem_rd     (mem_rd),
        .mem_data   (mem_data),
        .mem_ready  (mem_ready),
        .RegWrite   (RegWrite),
        .RD_Address (RD_Address),
        .RDdata     (RDdata),
        .busy_vec   (busy_vec)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required finish earlier");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        iss_valid = 1'b0; iss_rd = '0; rs_addr = '0; rt_addr = '0;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
    endtask

    task automatic apply_reset();
        idle();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        tests++;
        if ({RegWrite, RD_Address, RDdata, busy_vec, iss_ready, hazard} !==
            {1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL reset_state: got we=%b addr=%0d data=%h busy=%h iss_ready=%b hazard=%b, required 0/0/0/0/1/0",
                     RegWrite, RD_Address, RDdata, busy_vec, iss_ready, hazard);
        end
        iss_valid = 1'b1; iss_rd = 5'd9;
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h0000_00AA;
        tick();
        iss_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        tests++;
        if ({RegWrite, busy_vec} !== {1'b0, 32'd0}) begin
            fails++;
            $display("FAIL reset_midcycle: got we=%b busy=%h, required we=0 busy=0", RegWrite, busy_vec);
        end
        @(negedge clk);
        rst = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h0000_0033;
        mem_valid = 1'b1; mem_rd = 5'd4; mem_data = 32'h0000_0044;
        #1;
        tests++;
        if ({alu_ready, mem_ready} !== 2'b10) begin
            fails++;
            $display("FAIL reset_first_contention: got alu_ready=%b mem_ready=%b, required 1/0", alu_ready, mem_ready);
        end
        idle();
    endtask

    task automatic test_scoreboard();
        apply_reset();
        iss_valid = 1'b1; iss_rd = 5'd5; rs_addr = 5'd5;
        #1;
        tests++;
        if (iss_ready !== 1'b1) begin
            fails++;
            $display("FAIL sb_issue_ready: got %b, required 1", iss_ready);
        end
        tick();
        iss_valid = 1'b0;
        #1;
        tests++;
        if ({busy_vec[5], hazard} !== 2'b11) begin
            fails++;
            $display("FAIL sb_busy_set: got busy5=%b hazard=%b, required 1/1", busy_vec[5], hazard);
        end
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h0000_1234;
        tick();
        alu_valid = 1'b0;
        #1;
        tests++;
        if ({RegWrite, RD_Address, RDdata, busy_vec[5], hazard} !== {1'b1, 5'd5, 32'h1234, 1'b1, 1'b1}) begin
            fails++;
            $display("FAIL sb_writeback: got we=%b addr=%0d data=%h busy5=%b hazard=%b, required 1/5/00001234/1/1",
                     RegWrite, RD_Address, RDdata, busy_vec[5], hazard);
        end
        tick();
        tests++;
        if ({RegWrite, busy_vec[5], hazard} !== 3'b000) begin
            fails++;
            $display("FAIL sb_clear: got we=%b busy5=%b hazard=%b, required 0/0/0", RegWrite, busy_vec[5], hazard);
        end
        idle();
    endtask

    task automatic test_contention();
        logic          exp_alu;
        logic [AW-1:0] exp_rd;
        apply_reset();
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h0000_0033;
        mem_valid = 1'b1; mem_rd = 5'd4; mem_data = 32'h0000_0044;
        for (int i = 0; i < 4; i++) begin
            exp_alu = (i % 2 == 0);
            exp_rd  = exp_alu ? 5'd3 : 5'd4;
            #1;
            tests++;
            if ({alu_ready, mem_ready} !== {exp_alu, !exp_alu}) begin
                fails++;
                $display("FAIL contention_grant[%0d]: got alu=%b mem=%b, required alu=%b mem=%b",
                         i, alu_ready, mem_ready, exp_alu, !exp_alu);
            end
            tick();
            tests++;
            if ({RegWrite, RD_Address} !== {1'b1, exp_rd}) begin
                fails++;
                $display("FAIL contention_write[%0d]: got we=%b addr=%0d, required we=1 addr=%0d",
                         i, RegWrite, RD_Address, exp_rd);
            end
        end
        idle();
    endtask

    task automatic test_reg0();
        apply_reset();
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFF_FFFF;
        #1;
        tests++;
        if (alu_ready !== 1'b1) begin
            fails++;
            $display("FAIL r0_handshake: got alu_ready=%b, required 1", alu_ready);
        end
        tick();
        alu_valid = 1'b0;
        iss_valid = 1'b1; iss_rd = 5'd0;
        #1;
        tests++;
        if ({RegWrite, RDdata, iss_ready} !== {1'b0, 32'hFFFF_FFFF, 1'b1}) begin
            fails++;
            $display("FAIL r0_write: got we=%b data=%h iss_ready=%b, required 0/ffffffff/1", RegWrite, RDdata, iss_ready);
        end
        tick();
        tests++;
        if (busy_vec !== 32'd0) begin
            fails++;
            $display("FAIL r0_busy: got busy=%h, required 0", busy_vec);
        end
        idle();
    endtask

    task automatic test_waw();
        apply_reset();
        iss_valid = 1'b1; iss_rd = 5'd7;
        tick();
        mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'h0000_7777;
        #1;
        tests++;
        if ({iss_ready, mem_ready, busy_vec[7]} !== 3'b011) begin
            fails++;
            $display("FAIL waw_blocked: got iss_ready=%b mem_ready=%b busy7=%b, required 0/1/1", iss_ready, mem_ready, busy_vec[7]);
        end
        tick();
        mem_valid = 1'b0;
        #1;
        tests++;
        if ({iss_ready, RegWrite} !== 2'b01) begin
            fails++;
            $display("FAIL waw_grant_edge: got iss_ready=%b we=%b, required 0/1", iss_ready, RegWrite);
        end
        tick();
        tests++;
        if ({iss_ready, busy_vec[7]} !== 2'b10) begin
            fails++;
            $display("FAIL waw_released: got iss_ready=%b busy7=%b, required 1/0", iss_ready, busy_vec[7]);
        end
        idle();
    endtask

    task automatic test_stable_hold();
        logic [5:0] alu_pat;
        int         landed;
        int         gnt_cycle;
        logic       g;
        alu_pat   = 6'b101011;
        landed    = 0;
        gnt_cycle = -1;
        apply_reset();
        mem_valid = 1'b1; mem_rd = 5'd12; mem_data = 32'hCAFE_0012;
        for (int i = 0; i < 7; i++) begin
            alu_valid = (i < 6) ? alu_pat[i] : 1'b0;
            alu_rd    = AW'(i + 1);
            alu_data  = 32'(i);
            #1;
            g = mem_ready;
            if (g) gnt_cycle = i;
            tick();
            if (g) mem_valid = 1'b0;
            if (RegWrite && RD_Address == 5'd12 && RDdata == 32'hCAFE_0012) landed++;
        end
        tests++;
        if (gnt_cycle !== 1) begin
            fails++;
            $display("FAIL hold_grant_cycle: got %0d, required 1", gnt_cycle);
        end
        tests++;
        if (landed !== 1) begin
            fails++;
            $display("FAIL hold_landed_once: got %0d writes, required 1", landed);
        end
        idle();
    endtask

    task automatic test_random();
        logic [NR-1:0] m_busy;
        logic          m_last_mem;
        logic          m_we;
        logic [AW-1:0] m_addr;
        logic [DW-1:0] m_data;
        logic          e_alu, e_mem, e_iss, e_haz;
        logic          alu_hold, mem_hold;
        apply_reset();
        m_busy = '0; m_last_mem = 1'b1; m_we = 1'b0; m_addr = '0; m_data = '0;
        alu_hold = 1'b0; mem_hold = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!alu_hold) begin
                alu_valid = 1'($urandom_range(0, 1));
                alu_rd    = AW'($urandom_range(0, 7));
                alu_data  = $urandom;
            end
            if (!mem_hold) begin
                mem_valid = 1'($urandom_range(0, 1));
                mem_rd    = AW'($urandom_range(0, 7));
                mem_data  = $urandom;
            end
            alu_hold  = alu_valid;
            mem_hold  = mem_valid;
            iss_valid = 1'($urandom_range(0, 1));
            iss_rd    = AW'($urandom_range(0, 7));
            rs_addr   = AW'($urandom_range(0, 7));
            rt_addr   = AW'($urandom_range(0, 7));
            #1;
            if (alu_valid && mem_valid) begin
                e_alu = m_last_mem;
                e_mem = !m_last_mem;
            end else begin
                e_alu = alu_valid;
                e_mem = mem_valid;
            end
            e_iss = (iss_rd == 0) || !m_busy[iss_rd];
            e_haz = (rs_addr != 0 && m_busy[rs_addr]) || (rt_addr != 0 && m_busy[rt_addr]);
            tests++;
            if ({alu_ready, mem_ready, iss_ready, hazard} !== {e_alu, e_mem, e_iss, e_haz}) begin
                fails++;
                $display("FAIL rnd_comb[%0d]: got alu/mem/iss/haz=%b%b%b%b, required %b%b%b%b",
                         c, alu_ready, mem_ready, iss_ready, hazard, e_alu, e_mem, e_iss, e_haz);
            end
            tick();
            if (iss_valid && e_iss && iss_rd != 0) m_busy[iss_rd] = 1'b1;
            if (m_we) m_busy[m_addr] = 1'b0;
            if (e_alu) begin
                m_we = (alu_rd != 0); m_addr = alu_rd; m_data = alu_data; m_last_mem = 1'b0;
                alu_hold = 1'b0;
            end else if (e_mem) begin
                m_we = (mem_rd != 0); m_addr = mem_rd; m_data = mem_data; m_last_mem = 1'b1;
                mem_hold = 1'b0;
            end else begin
                m_we = 1'b0;
            end
            tests++;
            if ({RegWrite, RD_Address, RDdata, busy_vec} !== {m_we, m_addr, m_data, m_busy}) begin
                fails++;
                $display("FAIL rnd_regs[%0d]: got we=%b addr=%0d data=%h busy=%h, required we=%b addr=%0d data=%h busy=%h",
                         c, RegWrite, RD_Address, RDdata, busy_vec, m_we, m_addr, m_data, m_busy);
            end
        end
        idle();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst   = 1'b0;
        idle();
        test_reset();
        test_scoreboard();
        test_contention();
        test_reg0();
        test_waw();
        test_stable_hold();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
